// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 16-bit memory port among NUM_MASTERS masters.
// Ports: clk, reset; m_* per-master buses; s_* shared port; grant, busy.
module mem_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 19,
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*16-1:0]       m_data_out,
  input  logic [NUM_MASTERS-1:0]          m_wr_en,
  input  logic [NUM_MASTERS*2-1:0]        m_bytesel,
  input  logic [NUM_MASTERS-1:0]          m_access,
  output logic [NUM_MASTERS-1:0]          m_ack,
  output logic [15:0]                     m_data_in,
  output logic [ADDR_WIDTH:1]             s_addr,
  output logic [15:0]                     s_data_out,
  output logic                            s_wr_en,
  output logic [1:0]                      s_bytesel,
  output logic                            s_access,
  input  logic [15:0]                     s_data_in,
  input  logic                            s_ack,
  output logic [2:0]                      grant,
  output logic                            busy
);

  typedef enum logic {IDLE, OWNED} state_e;

  state_e     state_q;
  logic [2:0] grant_q;
  logic [2:0] last_q;
  logic [2:0] win_d;
  logic       owned;
  logic       wr_sel;
  logic [1:0] bsel_sel;

  assign owned     = (state_q == OWNED);
  assign busy      = owned;
  assign grant     = grant_q;
  assign s_access  = owned;
  assign m_data_in = s_data_in;

  // Walk the search order backwards so the
  // first requester in that order is the
  // last assignment and therefore wins.
  always_comb begin : arb
    int idx;
    win_d = grant_q;
    idx   = 0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (ROUND_ROBIN)
        idx = (int'(last_q) + 1 + k) % NUM_MASTERS;
      else
        idx = k;
      if (m_access[idx])
        win_d = 3'(idx);
    end
  end

  // Address and data follow grant even when
  // idle, so they keep the last owner's values.
  always_comb begin : mux
    s_addr     = m_addr[ADDR_WIDTH-1:0];
    s_data_out = m_data_out[15:0];
    wr_sel     = m_wr_en[0];
    bsel_sel   = m_bytesel[1:0];
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q == 3'(i)) begin
        s_addr     = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_data_out = m_data_out[i*16 +: 16];
        wr_sel     = m_wr_en[i];
        bsel_sel   = m_bytesel[i*2 +: 2];
      end
    end
  end

  assign s_wr_en   = owned & wr_sel;
  assign s_bytesel = owned ? bsel_sel : 2'b00;

  // Reset kills the ack pulse in the same
  // cycle so an abandoned transfer never acks.
  always_comb begin : ack
    m_ack = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      m_ack[i] = owned & s_ack & ~reset
               & (grant_q == 3'(i));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 3'(NUM_MASTERS - 1);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|m_access) begin
            state_q <= OWNED;
            grant_q <= win_d;
            last_q  <= win_d;
          end
        end
        OWNED: begin
          if (s_ack)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
